// File: rtl/vc_arbiter.sv
// Pops one word per cycle from VC0/VC1 (strict priority with an anti-starvation
// override for VC1) and steers it to D0 or D1 by a routing bit in the word.
module vc_arbiter #(
  parameter int BW       = 6,
  parameter int DEST_BIT = 4,
  parameter int STARVE   = 4
) (
  input  logic          clk,
  input  logic          reset_L,
  input  logic          VC0_empty,
  input  logic [BW-1:0] VC0_data_out,
  input  logic          VC1_empty,
  input  logic [BW-1:0] VC1_data_out,
  input  logic          D0_almost_full,
  input  logic          D1_almost_full,
  output logic          VC0_rd,
  output logic          VC1_rd,
  output logic          D0_push,
  output logic [BW-1:0] D0_data_in,
  output logic          D1_push,
  output logic [BW-1:0] D1_data_in,
  output logic          arb_idle
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE);

  logic          run_q;
  logic [3:0]    starve_q, starve_d;
  logic          s1_vld_q, s1_vld_d;
  logic          s1_vc_q, s1_vc_d;
  logic          d0_push_q, d0_push_d;
  logic          d1_push_q, d1_push_d;
  logic [BW-1:0] d0_data_q, d0_data_d;
  logic [BW-1:0] d1_data_q, d1_data_d;
  logic          go;
  logic          gnt0, gnt1;
  logic [BW-1:0] word;

  // Both destinations need room since the route is only known after the pop.
  always_comb begin
    go   = !D0_almost_full && !D1_almost_full;
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (run_q && go) begin
      if (starve_q == STARVE_LIM && !VC1_empty) gnt1 = 1'b1;
      else if (!VC0_empty)                      gnt0 = 1'b1;
      else if (!VC1_empty)                      gnt1 = 1'b1;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (VC1_empty || gnt1)
      starve_d = 4'd0;
    else if (gnt0 && starve_q != STARVE_LIM)
      starve_d = starve_q + 4'd1;
  end

  always_comb begin
    s1_vld_d  = gnt0 || gnt1;
    s1_vc_d   = gnt1;
    word      = s1_vc_q ? VC1_data_out : VC0_data_out;
    d0_push_d = 1'b0;
    d1_push_d = 1'b0;
    d0_data_d = d0_data_q;
    d1_data_d = d1_data_q;
    if (s1_vld_q) begin
      if (word[DEST_BIT]) begin
        d1_push_d = 1'b1;
        d1_data_d = word;
      end else begin
        d0_push_d = 1'b1;
        d0_data_d = word;
      end
    end
  end

  // run_q holds off grants until the first edge after reset release.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      run_q     <= 1'b0;
      starve_q  <= 4'd0;
      s1_vld_q  <= 1'b0;
      s1_vc_q   <= 1'b0;
      d0_push_q <= 1'b0;
      d1_push_q <= 1'b0;
      d0_data_q <= '0;
      d1_data_q <= '0;
    end else begin
      run_q     <= 1'b1;
      starve_q  <= starve_d;
      s1_vld_q  <= s1_vld_d;
      s1_vc_q   <= s1_vc_d;
      d0_push_q <= d0_push_d;
      d1_push_q <= d1_push_d;
      d0_data_q <= d0_data_d;
      d1_data_q <= d1_data_d;
    end
  end

  assign VC0_rd     = gnt0;
  assign VC1_rd     = gnt1;
  assign D0_push    = d0_push_q;
  assign D1_push    = d1_push_q;
  assign D0_data_in = d0_data_q;
  assign D1_data_in = d1_data_q;
  assign arb_idle   = run_q && !gnt0 && !gnt1 && !s1_vld_q && !d0_push_q && !d1_push_q;

endmodule

// File: tb/tb_vc_arbiter.sv
// Directed bench for vc_arbiter: behavioural VC FIFO models feed the arbiter and
// each task checks cycle-by-cycle strobes and data against hand-derived tables.
module tb_vc_arbiter;
  localparam int BW = 6;

  logic          clk = 1'b0;
  logic          reset_L;
  logic          VC0_empty, VC1_empty;
  logic [BW-1:0] VC0_data_out, VC1_data_out;
  logic          D0_almost_full, D1_almost_full;
  logic          VC0_rd, VC1_rd, D0_push, D1_push, arb_idle;
  logic [BW-1:0] D0_data_in, D1_data_in;

  logic [BW-1:0] mem0 [0:15];
  logic [BW-1:0] mem1 [0:15];
  int wp0, rp0, wp1, rp1;
  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  vc_arbiter #(.BW(BW), .DEST_BIT(4), .STARVE(4)) dut (
    .clk(clk), .reset_L(reset_L),
    .VC0_empty(VC0_empty), .VC0_data_out(VC0_data_out),
    .VC1_empty(VC1_empty), .VC1_data_out(VC1_data_out),
    .D0_almost_full(D0_almost_full), .D1_almost_full(D1_almost_full),
    .VC0_rd(VC0_rd), .VC1_rd(VC1_rd),
    .D0_push(D0_push), .D0_data_in(D0_data_in),
    .D1_push(D1_push), .D1_data_in(D1_data_in),
    .arb_idle(arb_idle)
  );

  // VC FIFO models: empty updates with the read pointer, data is valid the cycle after rd.
  assign VC0_empty = (wp0 == rp0);
  assign VC1_empty = (wp1 == rp1);

  always @(posedge clk) begin
    if (!reset_L) begin
      rp0 <= 0;
      rp1 <= 0;
    end else begin
      if (VC0_rd) begin
        VC0_data_out <= mem0[rp0];
        rp0 <= rp0 + 1;
      end
      if (VC1_rd) begin
        VC1_data_out <= mem1[rp1];
        rp1 <= rp1 + 1;
      end
    end
  end

  task automatic start_reset();
    reset_L = 1'b0;
    D0_almost_full = 1'b0;
    D1_almost_full = 1'b0;
    wp0 = 0;
    wp1 = 0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset_L = 1'b1;
  endtask

  task automatic test_reset();
    start_reset();
    mem0[0] = 6'h01; mem0[1] = 6'h02; mem0[2] = 6'h03; wp0 = 3;
    mem1[0] = 6'h11; wp1 = 1;
    #1;
    vec_cnt++;
    if ({VC0_rd, VC1_rd, D0_push, D1_push, arb_idle} !== 5'b0) begin
      err_cnt++;
      $display("FAIL reset_strobes got %b expected 00000", {VC0_rd, VC1_rd, D0_push, D1_push, arb_idle});
    end
    vec_cnt++;
    if ({D0_data_in, D1_data_in} !== '0) begin
      err_cnt++;
      $display("FAIL reset_data got %h/%h expected 00/00", D0_data_in, D1_data_in);
    end
    @(posedge clk); #1;
    vec_cnt++;
    if ({VC0_rd, VC1_rd} !== 2'b00) begin
      err_cnt++;
      $display("FAIL reset_hold_rd got %b expected 00", {VC0_rd, VC1_rd});
    end
    release_reset();
    @(posedge clk); #1;
    vec_cnt++;
    if ({VC0_rd, VC1_rd} !== 2'b10) begin
      err_cnt++;
      $display("FAIL reset_first_rd got %b expected 10", {VC0_rd, VC1_rd});
    end
  endtask

  task automatic test_priority_routing();
    logic [3:0] exp_v;
    start_reset();
    mem0[0] = 6'h05; mem0[1] = 6'h15; wp0 = 2;
    release_reset();
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      exp_v = {c < 2, 1'b0, c == 2, c == 3};
      vec_cnt++;
      if ({VC0_rd, VC1_rd, D0_push, D1_push} !== exp_v) begin
        err_cnt++;
        $display("FAIL prio_strobes c=%0d got %b expected %b", c, {VC0_rd, VC1_rd, D0_push, D1_push}, exp_v);
      end
      if (c == 2 || c == 3) begin
        vec_cnt++;
        if (D0_data_in !== 6'h05) begin
          err_cnt++;
          $display("FAIL prio_d0_data c=%0d got %h expected 05", c, D0_data_in);
        end
      end
      if (c == 3) begin
        vec_cnt++;
        if (D1_data_in !== 6'h15) begin
          err_cnt++;
          $display("FAIL prio_d1_data got %h expected 15", D1_data_in);
        end
      end
      if (c == 4) begin
        vec_cnt++;
        if (arb_idle !== 1'b1) begin
          err_cnt++;
          $display("FAIL prio_idle got %b expected 1", arb_idle);
        end
      end
    end
  endtask

  task automatic test_starvation();
    logic [11:0] gseq;
    logic [3:0]  exp_v;
    logic        g;
    int n0, n1;
    gseq = 12'b0000_1000_0100;
    start_reset();
    for (int i = 0; i < 10; i++) mem0[i] = 6'(i);
    wp0 = 10;
    mem1[0] = 6'h10; mem1[1] = 6'h11; wp1 = 2;
    n0 = 0; n1 = 0;
    release_reset();
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      exp_v = 4'b0000;
      if (c < 12) begin
        g = gseq[11-c];
        exp_v[3] = !g;
        exp_v[2] = g;
      end
      if (c >= 2 && c < 14) begin
        g = gseq[13-c];
        exp_v[1] = !g;
        exp_v[0] = g;
      end
      vec_cnt++;
      if ({VC0_rd, VC1_rd, D0_push, D1_push} !== exp_v) begin
        err_cnt++;
        $display("FAIL starve_strobes c=%0d got %b expected %b", c, {VC0_rd, VC1_rd, D0_push, D1_push}, exp_v);
      end
      if (exp_v[1]) begin
        vec_cnt++;
        if (D0_data_in !== mem0[n0]) begin
          err_cnt++;
          $display("FAIL starve_d0_data c=%0d got %h expected %h", c, D0_data_in, mem0[n0]);
        end
        n0++;
      end
      if (exp_v[0]) begin
        vec_cnt++;
        if (D1_data_in !== mem1[n1]) begin
          err_cnt++;
          $display("FAIL starve_d1_data c=%0d got %h expected %h", c, D1_data_in, mem1[n1]);
        end
        n1++;
      end
    end
  endtask

  task automatic test_back_pressure();
    logic [2:0] exp_v;
    int n0, seen;
    start_reset();
    for (int i = 0; i < 8; i++) mem0[i] = 6'(i);
    wp0 = 8;
    n0 = 0; seen = 0;
    release_reset();
    for (int c = 0; c < 16; c++) begin
      @(posedge clk); #1;
      D1_almost_full = (c >= 3 && c <= 7);
      #1;
      exp_v = {(c < 3) || (c >= 8 && c <= 12), 1'b0,
               (c >= 2 && c <= 4) || (c >= 10 && c <= 14)};
      vec_cnt++;
      if ({VC0_rd, VC1_rd, D0_push} !== exp_v) begin
        err_cnt++;
        $display("FAIL bp_strobes c=%0d got %b expected %b", c, {VC0_rd, VC1_rd, D0_push}, exp_v);
      end
      if (D0_push) seen++;
      if (exp_v[0]) begin
        vec_cnt++;
        if (D0_data_in !== 6'(n0)) begin
          err_cnt++;
          $display("FAIL bp_data c=%0d got %h expected %h", c, D0_data_in, 6'(n0));
        end
        n0++;
      end
    end
    D1_almost_full = 1'b0;
    vec_cnt++;
    if (seen != 8) begin
      err_cnt++;
      $display("FAIL bp_push_count got %0d expected 8", seen);
    end
  endtask

  task automatic test_empty_edge();
    logic [4:0] exp_v;
    int rd1;
    start_reset();
    mem1[0] = 6'h12; wp1 = 1;
    rd1 = 0;
    release_reset();
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      exp_v = {1'b0, c == 0, 1'b0, c == 2, c >= 3};
      vec_cnt++;
      if ({VC0_rd, VC1_rd, D0_push, D1_push, arb_idle} !== exp_v) begin
        err_cnt++;
        $display("FAIL empty_strobes c=%0d got %b expected %b", c, {VC0_rd, VC1_rd, D0_push, D1_push, arb_idle}, exp_v);
      end
      if (VC1_rd) rd1++;
      if (c == 2) begin
        vec_cnt++;
        if (D1_data_in !== 6'h12) begin
          err_cnt++;
          $display("FAIL empty_data got %h expected 12", D1_data_in);
        end
      end
    end
    vec_cnt++;
    if (rd1 != 1) begin
      err_cnt++;
      $display("FAIL empty_rd_count got %0d expected 1", rd1);
    end
  endtask

  task automatic test_reset_mid();
    logic [2:0] exp_v;
    start_reset();
    mem0[0] = 6'h03; mem0[1] = 6'h13; mem0[2] = 6'h07; wp0 = 3;
    release_reset();
    repeat (3) @(posedge clk);
    #1;
    vec_cnt++;
    if ({D0_push, D0_data_in} !== {1'b1, 6'h03}) begin
      err_cnt++;
      $display("FAIL mid_pre_push got %b/%h expected 1/03", D0_push, D0_data_in);
    end
    reset_L = 1'b0;
    wp0 = 0;
    wp1 = 0;
    #1;
    vec_cnt++;
    if ({VC0_rd, VC1_rd, D0_push, D1_push} !== 4'b0000) begin
      err_cnt++;
      $display("FAIL mid_async_clear got %b expected 0000", {VC0_rd, VC1_rd, D0_push, D1_push});
    end
    vec_cnt++;
    if (D0_data_in !== 6'h00) begin
      err_cnt++;
      $display("FAIL mid_data_clear got %h expected 00", D0_data_in);
    end
    repeat (2) @(posedge clk);
    release_reset();
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      exp_v = 3'b001;
      vec_cnt++;
      if ({D0_push, D1_push, arb_idle} !== exp_v) begin
        err_cnt++;
        $display("FAIL mid_post c=%0d got %b expected %b", c, {D0_push, D1_push, arb_idle}, exp_v);
      end
    end
  endtask

  initial begin
    reset_L = 1'b0;
    D0_almost_full = 1'b0;
    D1_almost_full = 1'b0;
    wp0 = 0; wp1 = 0;
    test_reset();
    test_priority_routing();
    test_starvation();
    test_back_pressure();
    test_empty_edge();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/vc_arbiter.md
Name: vc_arbiter

Overview:
- Downstream consumer of the VC0 and VC1 virtual-channel FIFOs.
- Each cycle it selects at most one non-empty VC and pops one word from it. Selection is strict priority VC0 > VC1, with an anti-starvation override.
- The popped word is steered to destination FIFO D0 or D1 by a routing bit in the word.
- Destination back-pressure is honoured via the destination almost_full flags.

Parameters:
- BW, 6, data width in bits (matches VC FIFO width).
- DEST_BIT, 4, bit index of the word that selects the destination (0 -> D0, 1 -> D1).
- STARVE, 4, maximum consecutive VC0 grants while VC1 is non-empty before VC1 is forced a grant (range 1..15).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset_L  in  1  asynchronous, active-low reset.
- VC0_empty  in  1  empty flag of VC0 FIFO.
- VC0_data_out  in  BW  VC0 FIFO read data; valid the cycle after VC0_rd.
- VC1_empty  in  1  empty flag of VC1 FIFO.
- VC1_data_out  in  BW  VC1 FIFO read data; valid the cycle after VC1_rd.
- D0_almost_full  in  1  almost-full flag of destination FIFO D0.
- D1_almost_full  in  1  almost-full flag of destination FIFO D1.
- VC0_rd  out  1  pop strobe to VC0.
- VC1_rd  out  1  pop strobe to VC1.
- D0_push  out  1  write strobe to D0.
- D0_data_in  out  BW  write data to D0.
- D1_push  out  1  write strobe to D1.
- D1_data_in  out  BW  write data to D1.
- arb_idle  out  1  high when no read is issued and no word is in flight.

Behaviour:
- Reset (reset_L=0, asynchronous): all outputs 0; starvation counter 0; pipeline valids 0. Any in-flight word is discarded. Normal operation begins on the first rising edge after reset_L rises.
- Grant logic (combinational on current inputs and state):
  - go = !D0_almost_full && !D1_almost_full.
  - The destination is unknown before the read, so both destinations must have room.
  - If go=0, neither rd is asserted.
- Grant selection when go=1:
  - VC1 is granted if starve_cnt==STARVE and VC1_empty=0.
  - Otherwise VC0 is granted if VC0_empty=0.
  - Otherwise VC1 is granted if VC1_empty=0.
  - Otherwise there is no grant.
- VC0_rd and VC1_rd are never high together.
- VC FIFO contract: empty flags update on the same edge as the read pointer, so back-to-back pops are legal, including a pop of the last word.
- Starvation counter (4-bit, saturating at STARVE):
  - Increments on a VC0 grant while VC1_empty=0.
  - Clears on a VC1 grant or when VC1_empty=1.
  - Holds otherwise.
- Pipeline (2 stages):
  - Stage 1: sel_q, the registered grant (valid plus source VC).
  - Stage 2: on the edge after stage 1 is valid, the arbiter captures VCx_data_out selected by sel_q and drives it out.
  - If data[DEST_BIT]=0: D0_push=1, D0_data_in=data. Otherwise: D1_push=1, D1_data_in=data.
  - The unused destination's push is 0; its data output holds its last value.
  - Latency is rd high in cycle N -> push high in cycle N+2.
  - Throughput is one word per cycle.
- Dx_push is high for exactly one cycle per popped word. Words from the same VC arrive in pop order.
- Back-pressure margin: up to 2 words may be in flight when almost_full rises. Destination FIFO thresholds must leave at least 2 free slots when almost_full asserts. The arbiter does not retract issued reads.
- arb_idle = !VC0_rd && !VC1_rd && !stage1_valid && !stage2_valid.
- Simultaneous events:
  - Both VCs non-empty with starve_cnt<STARVE: VC0 wins.
  - almost_full rising in the same cycle as a grant: the grant is suppressed that cycle.
  - Reset asserted mid-stream: pushes drop to 0 immediately; no partial word is written after reset release.

Test Plan:
- Reset: reset_L=0 with both VCs non-empty -> all outputs 0. Release reset -> VC0_rd=1 on the first cycle after release.
- Priority/routing: VC0 holds {0x05, 0x15}, VC1 empty, no back-pressure -> VC0_rd high 2 cycles. D0_push with 0x05 at N+2; D1_push with 0x15 at N+3.
- Starvation (STARVE=4): VC0 holds 10 words, VC1 holds 2 words -> grant sequence VC0 x4, VC1, VC0 x4, VC1, VC0 x2.
- Back-pressure: D1_almost_full=1 for 5 cycles mid-stream -> no rd during those cycles. At most 2 pushes complete after assertion. Stream resumes the cycle after deassertion with no word lost or duplicated.
- Empty edge: VC1 holds 1 word, VC0 empty -> exactly one VC1_rd. One push at +2 cycles. arb_idle=1 from the cycle after the push.
- Reset mid-operation: assert reset_L=0 while 2 words are in flight -> D0_push and D1_push go to 0 asynchronously. No push occurs in the first 2 cycles after release unless a new rd was issued.
